// File: rtl/yarith_pkg.sv
// Shared types and constants for the bit-serial arithmetic blocks.
package yarith_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int W_DEFAULT = 8;

    function automatic int cnt_width(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

endpackage

// File: rtl/yfa_cell.sv
// Single-bit full adder cell; the only combinational arithmetic in the serial datapath.
module yfa_cell (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/yserial_addsub.sv
// Bit-serial add/subtract: operands shift LSB-first through one full-adder cell,
// one bit per clock, with the carry held in a register between bits.
module yserial_addsub
    import yarith_pkg::*;
#(
    parameter int W = W_DEFAULT
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic         sub,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] z,
    output logic         cout,
    output logic         ovf
);

    localparam int CW = cnt_width(W);
    localparam logic [CW-1:0] LAST = CW'(W - 1);

    state_t        state, state_nxt;
    logic [W-1:0]  ra, rb;
    logic          carry;
    logic [CW-1:0] cnt;
    logic          fa_s, fa_c;

    yfa_cell u_fa (
        .a    (ra[0]),
        .b    (rb[0]),
        .cin  (carry),
        .s    (fa_s),
        .cout (fa_c)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = SHIFT;
            SHIFT:   if (cnt == LAST) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            ra    <= '0;
            rb    <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            z     <= '0;
            cout  <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (start) begin
                        // Subtraction is a + ~b + 1: the +1 rides in as the initial carry.
                        ra    <= a;
                        rb    <= sub ? ~b : b;
                        carry <= sub;
                        cnt   <= '0;
                    end
                end
                SHIFT: begin
                    ra    <= ra >> 1;
                    rb    <= rb >> 1;
                    z     <= {fa_s, z[W-1:1]};
                    carry <= fa_c;
                    cnt   <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        cout <= fa_c;
                        ovf  <= carry ^ fa_c;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy = (state != IDLE);
    assign done = (state == DONE);

endmodule

// File: tb/tb_yserial_addsub.sv
// Randomised and directed checks of yserial_addsub against a latency/arithmetic model.
module tb_yserial_addsub;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         start = 1'b0;
    logic         sub = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         busy, done, cout, ovf;
    logic [W-1:0] z;

    int total = 0;
    int bad   = 0;

    yserial_addsub #(.W(W)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .sub   (sub),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .z     (z),
        .cout  (cout),
        .ovf   (ovf)
    );

    always #5 clk = ~clk;

    // Model: phase counts cycles since start was accepted (0 = idle, W+1 = done cycle).
    int           m_phase = 0;
    logic [W-1:0] m_z = '0, p_z = '0;
    logic         m_cout = 1'b0, m_ovf = 1'b0, p_cout = 1'b0, p_ovf = 1'b0;

    always @(posedge clk or posedge reset) begin
        logic [W-1:0] bb;
        logic [W:0]   sum;
        if (reset) begin
            m_phase = 0;
            m_z = '0; m_cout = 1'b0; m_ovf = 1'b0;
        end else if (m_phase == 0) begin
            if (start) begin
                bb     = sub ? ~b : b;
                sum    = {1'b0, a} + {1'b0, bb} + {{W{1'b0}}, sub};
                p_z    = sum[W-1:0];
                p_cout = sum[W];
                p_ovf  = (a[W-1] == bb[W-1]) && (sum[W-1] != a[W-1]);
                m_phase = 1;
            end
        end else if (m_phase == W + 1) begin
            m_phase = 0;
        end else begin
            m_phase = m_phase + 1;
            if (m_phase == W + 1) begin
                m_z = p_z; m_cout = p_cout; m_ovf = p_ovf;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            chk("busy", 32'(busy), 32'(m_phase != 0));
            chk("done", 32'(done), 32'(m_phase == W + 1));
            if (m_phase == 0 || m_phase == W + 1) begin
                chk("z", 32'(z), 32'(m_z));
                chk("cout", 32'(cout), 32'(m_cout));
                chk("ovf", 32'(ovf), 32'(m_ovf));
            end
        end
    end

    task automatic run_op(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic isub,
                          input logic [W-1:0] ez, input logic ec, input logic eo);
        int lat;
        a = ia; b = ib; sub = isub; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (done) begin
                lat = k;
                break;
            end
        end
        if (lat == 0) begin
            chk("done_timeout", 32'd0, 32'd1);
        end else begin
            chk("latency", 32'(lat), 32'(W + 1));
            chk("lit_z", 32'(z), 32'(ez));
            chk("lit_cout", 32'(cout), 32'(ec));
            chk("lit_ovf", 32'(ovf), 32'(eo));
            chk("model_z", 32'(m_z), 32'(ez));
            chk("model_flags", 32'({m_cout, m_ovf}), 32'({ec, eo}));
        end
        @(posedge clk); #1;
    endtask

    initial begin
        int dcnt;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_z", 32'(z), 32'd0);

        run_op(8'h35, 8'h4A, 1'b0, 8'h7F, 1'b0, 1'b0);
        run_op(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
        run_op(8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);
        run_op(8'h10, 8'h20, 1'b1, 8'hF0, 1'b0, 1'b0);
        run_op(8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1);

        // Requests arriving while busy (mid-shift and in the done cycle) are dropped.
        a = 8'h01; b = 8'h01; sub = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        dcnt = 0;
        for (int k = 1; k <= 14; k++) begin
            start = (k == 3 || k == 9);
            a = 8'hAA; b = 8'h55;
            @(negedge clk);
            if (done) begin
                dcnt++;
                chk("ignore_z", 32'(z), 32'h02);
            end
            @(posedge clk); #1;
        end
        start = 1'b0;
        chk("ignore_dones", 32'(dcnt), 32'd1);
        chk("ignore_idle", 32'(busy), 32'd0);

        a = 8'h0F; b = 8'h01; sub = 1'b0; start = 1'b1;
        dcnt = 0;
        for (int k = 0; k <= 30; k++) begin
            @(negedge clk);
            if (done) begin
                dcnt++;
                chk("b2b_z", 32'(z), 32'h10);
            end
        end
        start = 1'b0;
        chk("b2b_dones", 32'(dcnt), 32'd3);
        repeat (3) @(posedge clk); #1;

        a = 8'h12; b = 8'h34; sub = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #2 reset = 1'b1;
        #1;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_z", 32'(z), 32'd0);
        chk("abort_flags", 32'({cout, ovf}), 32'd0);
        @(posedge clk); #1 reset = 1'b0;
        run_op(8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1'b0);

        for (int k = 0; k < 600; k++) begin
            start = ($urandom_range(2) == 0);
            a     = W'($urandom);
            b     = W'($urandom);
            sub   = 1'($urandom);
            @(posedge clk); #1;
        end
        start = 1'b0;
        repeat (W + 4) @(posedge clk);
        #1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
